// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences a single request through an external ALU.
// Flow: IDLE -> LOAD_Y -> EXEC (N cycles) -> RESP, with result held until accepted.
// Optional HI/LO register file with mfhi/mflo shortcut, enabled by defining
// the macro ALU_ISSUE_HILO_EN (default build: disabled, hi_out/lo_out tied to 0).
module alu_issue_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int EXEC_CYCLES   = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_branch,
    output logic [31:0] alu_y,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    output logic        alu_branch_flag,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    // Cycle counts clamped to at least one EXEC cycle
    localparam int unsigned EXEC_N   = (EXEC_CYCLES   < 1) ? 32'd1 : 32'(EXEC_CYCLES);
    localparam int unsigned MULDIV_N = (MULDIV_CYCLES < 1) ? 32'd1 : 32'(MULDIV_CYCLES);
    localparam int unsigned MAX_N    = (EXEC_N > MULDIV_N) ? EXEC_N : MULDIV_N;
    // Counter only ever holds (cycles - 1)
    localparam int unsigned CNT_W    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CNT_W-1:0] EXEC_LOAD   = CNT_W'(EXEC_N - 1);
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_N - 1);

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
`ifdef ALU_ISSUE_HILO_EN
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_Y = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [31:0]      y_q, y_d;
    logic [31:0]      b_q, b_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      z_q, z_d;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             op_is_muldiv;

`ifdef ALU_ISSUE_HILO_EN
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
`endif

    // Latched opcode selects the long EXEC path
    assign op_is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        y_d     = y_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
`ifdef ALU_ISSUE_HILO_EN
        hi_d    = hi_q;
        lo_d    = lo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_opcode;
                    y_d     = req_a;
                    b_d     = req_b;
                    br_d    = req_branch;
                    state_d = S_LOAD_Y;
`ifdef ALU_ISSUE_HILO_EN
                    // HI/LO moves bypass the ALU entirely
                    if (req_opcode == OP_MFHI) begin
                        z_d     = {32'h0, hi_q};
                        state_d = S_RESP;
                    end else if (req_opcode == OP_MFLO) begin
                        z_d     = {32'h0, lo_q};
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_LOAD_Y: begin
                cnt_d   = op_is_muldiv ? MULDIV_LOAD : EXEC_LOAD;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    z_d     = alu_c;
                    state_d = S_RESP;
`ifdef ALU_ISSUE_HILO_EN
                    if (op_is_muldiv) begin
                        hi_d = alu_c[63:32];
                        lo_d = alu_c[31:0];
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_q        <= '0;
            y_q         <= '0;
            b_q         <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            z_q         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            y_q         <= y_d;
            b_q         <= b_d;
            br_q        <= br_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            req_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
        end
    end

`ifdef ALU_ISSUE_HILO_EN
    // HI/LO result registers written by mul/div
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
`else
    assign hi_out = '0;
    assign lo_out = '0;
`endif

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign alu_y           = y_q;
    assign alu_b           = b_q;
    assign alu_opcode      = op_q;
    assign alu_branch_flag = br_q;
    assign rsp_lo          = z_q[31:0];
    assign rsp_hi          = z_q[63:32];

endmodule
